// File: rtl/bram_port_arbiter.sv
// Two-port arbiter in front of a single-port BRAM. Port 0 is the core and
// port 1 is the loader. The arbiter picks one request per cycle and drives
// the BRAM. It tags each accepted read with its owner and returns
// bram_dout to that owner RD_LAT cycles later.
module bram_port_arbiter #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [31:0]       m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [31:0]       m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout
);

   logic              last_gnt;   // 0 = port 0 won last, 1 = port 1 won last
   logic              g0, g1;
   logic              rd_acc;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_o;     // owner of each in-flight read, 1 = port 1

   // Byte-offset and out-of-range address bits are dropped on purpose, which wraps accesses within the BRAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                               m1_addr[31:ADDR_W+2], m1_addr[1:0]};

   // Grant logic: a sole requester wins. On a tie, round-robin uses last_gnt, otherwise port 0 wins. Nothing is granted during reset.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (rstn) begin
         if (m0_req && m1_req) begin
            if (RR_EN && !last_gnt) g1 = 1'b1;
            else                    g0 = 1'b1;
         end else begin
            g0 = m0_req;
            g1 = m1_req;
         end
      end
   end

   // BRAM port drive: the granted port passes through. With no grant, addr and din hold their last value and we stays low.
   always_comb begin
      bram_addr = addr_q;
      bram_din  = din_q;
      bram_we   = 1'b0;
      rd_acc    = 1'b0;
      if (g1) begin
         bram_addr = m1_addr[ADDR_W+1:2];
         bram_din  = m1_wdata;
         bram_we   = m1_we;
         rd_acc    = ~m1_we;
      end else if (g0) begin
         bram_addr = m0_addr[ADDR_W+1:2];
         bram_din  = m0_wdata;
         bram_we   = m0_we;
         rd_acc    = ~m0_we;
      end
   end

   assign m0_gnt    = g0;
   assign m1_gnt    = g1;
   assign m0_rvalid = tag_v[RD_LAT-1] & ~tag_o[RD_LAT-1];
   assign m1_rvalid = tag_v[RD_LAT-1] &  tag_o[RD_LAT-1];
   assign m0_rdata  = bram_dout;
   assign m1_rdata  = bram_dout;

   // State: held BRAM address/data, round-robin history and the read tag pipeline.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q   <= '0;
         din_q    <= '0;
         last_gnt <= 1'b1;
         tag_v    <= '0;
         tag_o    <= '0;
      end else begin
         addr_q   <= bram_addr;
         din_q    <= bram_din;
         if (g0 || g1) last_gnt <= g1;
         tag_v[0] <= rd_acc;
         tag_o[0] <= g1;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_o[i] <= tag_o[i-1];
         end
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter. The main instance runs round-robin with a
// 2-cycle BRAM. A second instance runs fixed priority with a 1-cycle BRAM.
module tb_bram_port_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bram_we;
   logic [31:0] m0_rdata, m1_rdata, bram_din, bram_dout;
   logic [19:0] bram_addr;

   logic        f0_req = 0, f0_we = 0, f1_req = 0, f1_we = 0;
   logic [31:0] f0_addr = 0, f0_wdata = 0, f1_addr = 0, f1_wdata = 0;
   logic        f0_gnt, f0_rvalid, f1_gnt, f1_rvalid, fb_we;
   logic [31:0] f0_rdata, f1_rdata, fb_din, fb_dout;
   logic [19:0] fb_addr;

   int checks = 0;
   int errors = 0;

   bram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .RD_LAT(LAT), .RR_EN(1'b1)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout));

   bram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .RD_LAT(1), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rstn(rstn),
      .m0_req(f0_req), .m0_we(f0_we), .m0_addr(f0_addr), .m0_wdata(f0_wdata),
      .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
      .m1_req(f1_req), .m1_we(f1_we), .m1_addr(f1_addr), .m1_wdata(f1_wdata),
      .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
      .bram_we(fb_we), .bram_addr(fb_addr), .bram_din(fb_din), .bram_dout(fb_dout));

   // BRAM model for the main instance: read-first with a 2-stage output pipe.
   logic [31:0] bmem [int unsigned];
   logic [31:0] rpipe0 = 0, rpipe1 = 0;
   always @(posedge clk) begin
      rpipe0 <= bmem.exists(32'(bram_addr)) ? bmem[32'(bram_addr)] : 32'h0;
      rpipe1 <= rpipe0;
      if (bram_we) bmem[32'(bram_addr)] = bram_din;
   end
   assign bram_dout = rpipe1;

   // Second instance: the 1-cycle "BRAM" echoes back the word address.
   always @(posedge clk) fb_dout <= {12'h0, fb_addr};

   // Reference model state for the random test.
   typedef struct { int due; bit own; logic [31:0] data; } rsp_t;
   rsp_t        q[$];
   logic [31:0] ref_mem [int unsigned];
   bit          last_ref;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      m0_req = 0; m1_req = 0; f0_req = 0; f1_req = 0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   function automatic logic [31:0] mk_addr();
      logic [9:0] hi = 10'($urandom);
      logic [19:0] w = 20'(64 + $urandom_range(15));
      logic [1:0] lo = 2'($urandom);
      return {hi, w, lo};
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1; f0_req = 1; f1_req = 1;
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
      checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bram_we); end
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
      checks++; if ({f0_gnt, f1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_fp_gnt got %b exp 00", {f0_gnt, f1_gnt}); end
      apply_reset();
   endtask

   task automatic test_single_read();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b exp 10", {m0_gnt, m1_gnt}); end
      checks++; if (bram_addr !== 20'd4) begin errors++; $display("FAIL rd_addr got %0d exp 4", bram_addr); end
      checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", bram_we); end
      next_cycle(); m0_req = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++; if (m0_rvalid !== (c == LAT)) begin errors++; $display("FAIL rd_rvalid0 c%0d got %b exp %b", c, m0_rvalid, c == LAT); end
         checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 c%0d got %b exp 0", c, m1_rvalid); end
         next_cycle();
      end
   endtask

   task automatic test_write_then_read();
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", m1_gnt); end
      checks++; if ({bram_we, bram_addr} !== {1'b1, 20'd8}) begin errors++; $display("FAIL wr_port got we=%b addr=%0d exp we=1 addr=8", bram_we, bram_addr); end
      checks++; if (bram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_din got %h exp deadbeef", bram_din); end
      next_cycle(); m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h20;
      @(negedge clk);
      checks++; if ({m0_gnt, bram_we, bram_addr} !== {2'b10, 20'd8}) begin errors++; $display("FAIL raw_gnt got gnt=%b we=%b addr=%0d exp 1 0 8", m0_gnt, bram_we, bram_addr); end
      next_cycle(); m0_req = 0;
      repeat (LAT - 1) next_cycle();
      @(negedge clk);
      checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL raw_data got v=%b d=%h exp 1 deadbeef", m0_rvalid, m0_rdata); end
      checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL raw_rvalid1 got %b exp 0", m1_rvalid); end
      next_cycle();
   endtask

   task automatic test_round_robin();
      apply_reset();
      m0_we = 0; m1_we = 0; m0_addr = 32'h100; m1_addr = 32'h200;
      for (int c = 0; c < 7; c++) begin
         m0_req = (c < 4); m1_req = (c < 4);
         @(negedge clk);
         if (c < 4) begin
            checks++; if ({m0_gnt, m1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt c%0d got %b", c, {m0_gnt, m1_gnt}); end
         end
         checks++;
         if ({m0_rvalid, m1_rvalid} !== ((c >= LAT && c < LAT + 4) ? (((c - LAT) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00)) begin
            errors++; $display("FAIL rr_rvalid c%0d got %b", c, {m0_rvalid, m1_rvalid});
         end
         next_cycle();
      end
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      f0_we = 0; f1_we = 0; f0_addr = 32'h30; f1_addr = 32'h44;
      for (int c = 0; c < 5; c++) begin
         f0_req = (c < 3); f1_req = (c < 4);
         @(negedge clk);
         if (c < 4) begin
            checks++; if ({f0_gnt, f1_gnt} !== ((c < 3) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fp_gnt c%0d got %b", c, {f0_gnt, f1_gnt}); end
         end
         if (c >= 1 && c <= 3) begin
            checks++; if ({f0_rvalid, f1_rvalid, f0_rdata} !== {2'b10, 32'd12}) begin errors++; $display("FAIL fp_rsp0 c%0d got v=%b d=%0d exp 10 12", c, {f0_rvalid, f1_rvalid}, f0_rdata); end
         end
         if (c == 4) begin
            checks++; if ({f0_rvalid, f1_rvalid, f1_rdata} !== {2'b01, 32'd17}) begin errors++; $display("FAIL fp_rsp1 got v=%b d=%0d exp 01 17", {f0_rvalid, f1_rvalid}, f1_rdata); end
         end
         next_cycle();
      end
      f0_req = 0; f1_req = 0;
   endtask

   task automatic test_reset_inflight();
      apply_reset();
      m1_req = 1; m1_we = 0; m1_addr = 32'h40;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rst_m1gnt got %b exp 1", m1_gnt); end
      next_cycle(); m1_req = 0;
      #2 rstn = 1'b0;
      m0_req = 1; m1_req = 1; m0_we = 0; m0_addr = 32'h80;
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt, bram_we, m1_rvalid} !== 4'b0000) begin errors++; $display("FAIL rst_async got %b exp 0000", {m0_gnt, m1_gnt, bram_we, m1_rvalid}); end
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rst_first_tie got %b exp 10", {m0_gnt, m1_gnt}); end
      next_cycle(); m0_req = 0; m1_req = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_drop c%0d got %b exp 0", c, m1_rvalid); end
         next_cycle();
      end
   endtask

   task automatic test_wrap_idle();
      m0_req = 1; m0_we = 0; m0_addr = 32'h0040_0004;
      @(negedge clk);
      checks++; if ({m0_gnt, bram_addr} !== {1'b1, 20'd1}) begin errors++; $display("FAIL wrap got gnt=%b addr=%0d exp 1 1", m0_gnt, bram_addr); end
      next_cycle(); m0_req = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if ({bram_we, bram_addr} !== {1'b0, 20'd1}) begin errors++; $display("FAIL idle c%0d got we=%b addr=%0d exp 0 1", c, bram_we, bram_addr); end
         next_cycle();
      end
   endtask

   task automatic test_random();
      bit e0, e1;
      int unsigned idx;
      logic [31:0] d;
      apply_reset();
      q.delete();
      last_ref = 1'b1;
      for (int cyc = 0; cyc < 320; cyc++) begin
         if (cyc < 300) begin
            if (!m0_req && $urandom_range(2) != 0) begin m0_req = 1; m0_we = 1'($urandom_range(1)); m0_addr = mk_addr(); m0_wdata = $urandom; end
            if (!m1_req && $urandom_range(2) != 0) begin m1_req = 1; m1_we = 1'($urandom_range(1)); m1_addr = mk_addr(); m1_wdata = $urandom; end
         end
         e0 = m0_req && (!m1_req || last_ref);
         e1 = m1_req && !e0;
         @(negedge clk);
         checks++; if ({m0_gnt, m1_gnt} !== {e0, e1}) begin errors++; $display("FAIL rnd_gnt cyc%0d got %b exp %b", cyc, {m0_gnt, m1_gnt}, {e0, e1}); end
         if (e0 || e1) begin
            idx = ((e1 ? m1_addr : m0_addr) >> 2) & 32'hFFFFF;
            checks++;
            if ({bram_we, 32'(bram_addr)} !== {(e1 ? m1_we : m0_we), idx}) begin
               errors++; $display("FAIL rnd_port cyc%0d got we=%b addr=%0d exp addr=%0d", cyc, bram_we, bram_addr, idx);
            end
         end else begin
            checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL rnd_idle_we cyc%0d got %b exp 0", cyc, bram_we); end
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {!q[0].own, q[0].own} || (q[0].own ? m1_rdata : m0_rdata) !== q[0].data) begin
               errors++; $display("FAIL rnd_rsp cyc%0d got v=%b d0=%h d1=%h exp own=%0d d=%h", cyc, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, q[0].own, q[0].data);
            end
            void'(q.pop_front());
         end else begin
            checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rnd_norsp cyc%0d got %b exp 00", cyc, {m0_rvalid, m1_rvalid}); end
         end
         if (e0 || e1) begin
            if (e1 ? m1_we : m0_we) ref_mem[idx] = e1 ? m1_wdata : m0_wdata;
            else begin
               d = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
               q.push_back('{due: cyc + LAT, own: e1, data: d});
            end
            last_ref = e1;
         end
         next_cycle();
         if (e0) m0_req = 0;
         if (e1) m1_req = 0;
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_then_read();
      test_round_robin();
      test_fixed_priority();
      test_reset_inflight();
      test_wrap_idle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
